// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one combinational ADDU/SUBU datapath among NREQ
// requesters. Flow: IDLE (grant) -> EXEC (datapath enabled) -> RESP
// (hold the response until it is accepted).
// Optional feature: define ALU_SCHED_RR_EN for round-robin arbitration.
// When it is not defined, the lowest index wins and no pointer is built.
module alu_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_instr,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  output logic                  alu_reset,
  output logic                  alu_enable,
  output logic                  alu_instr,
  output logic [WIDTH-1:0]      alu_op1,
  output logic [WIDTH-1:0]      alu_op2,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carryout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             found;
  logic [IDW-1:0]   gnt_id;
  logic             grant;
  logic             alu_rst_q;
  logic             instr_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;

`ifdef ALU_SCHED_RR_EN
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // Round-robin pick: the first valid requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // After each grant, the pointer moves to the slot just past the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (grant)
      ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
  end
`else
  // Fixed-priority pick: scanning downward leaves the lowest valid index.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found  = 1'b1;
        gnt_id = IDW'(k);
      end
    end
  end
`endif

  // A grant needs IDLE and a datapath that is already out of reset. As a
  // result, req_ready stays low while reset_n is low.
  assign grant = (state == IDLE) && found && !alu_rst_q;

  // Drive the one-hot accept to the winner only.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. EXEC always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)     state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath reset is held through reset and drops on the first edge after
  // release. Nothing sets it again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alu_rst_q <= 1'b1;
    else          alu_rst_q <= 1'b0;
  end

  // Capture the winner's request at grant time. The datapath outputs are
  // captured at the end of EXEC. Both sets of registers hold their values
  // otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (grant) begin
        instr_q <= req_instr[gnt_id];
        op1_q   <= req_op1[gnt_id*WIDTH +: WIDTH];
        op2_q   <= req_op2[gnt_id*WIDTH +: WIDTH];
        id_q    <= gnt_id;
      end
      if (state == EXEC) begin
        res_q   <= alu_result;
        carry_q <= alu_carryout;
      end
    end
  end

  assign alu_reset  = alu_rst_q;
  assign alu_enable = (state == EXEC);
  assign alu_instr  = instr_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler. A behavioural datapath model
// drives alu_result/alu_carryout. Its carry flag is active-low
// (1 = no carry out of the 64-bit adder), which reproduces the reference
// values for the directed cases.
module tb_alu_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] req_valid, req_ready, req_instr;
  logic [NREQ*W-1:0] req_op1, req_op2;
  logic            alu_reset, alu_enable, alu_instr;
  logic [W-1:0]    alu_op1, alu_op2, alu_result;
  logic            alu_carryout;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_result;
  logic            rsp_carry;

  int errors = 0;
  int checks = 0;
  int rr_ptr = 0;

  alu_scheduler #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_op1(req_op1), .req_op2(req_op2),
    .alu_reset(alu_reset), .alu_enable(alu_enable), .alu_instr(alu_instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  // Datapath model: result in [63:0], active-low carry flag in [64].
  function automatic logic [W:0] dp(input logic i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = i ? ({1'b0, a} + {1'b0, ~b} + 65'd1) : ({1'b0, a} + {1'b0, b});
    return {~s[W], s[W-1:0]};
  endfunction

  assign {alu_carryout, alu_result} = dp(alu_instr, alu_op1, alu_op2);

  // Arbitration reference: returns the expected winner, or -1 if none.
  function automatic int pick(input logic [NREQ-1:0] m);
    int idx;
`ifdef ALU_SCHED_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr_ptr + k) % NREQ;
      if (m[idx[1:0]]) return idx;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (m[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int id, input logic ins, input logic [W-1:0] a, input logic [W-1:0] b);
    req_instr[id]        = ins;
    req_op1[id*W +: W]   = a;
    req_op2[id*W +: W]   = b;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = '0; req_instr = '0; req_op1 = '0; req_op2 = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0010;  // a request under reset must not be accepted
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    checks++; if (alu_reset !== 1'b1) begin errors++; $display("FAIL rst_alu_reset got=%b exp=1", alu_reset); end
    checks++; if ({alu_enable, alu_instr, rsp_valid, rsp_carry} !== 4'b0) begin errors++; $display("FAIL rst_ctl got=%b exp=0000", {alu_enable, alu_instr, rsp_valid, rsp_carry}); end
    checks++; if ({alu_op1, alu_op2, rsp_result} !== '0) begin errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", alu_op1, alu_op2, rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id got=%0d exp=0", rsp_id); end
    req_valid = '0;
    reset_n = 1'b1;
    #1;
    checks++; if (alu_reset !== 1'b1) begin errors++; $display("FAIL rel_alu_reset got=%b exp=1", alu_reset); end
    @(posedge clk); #1;
    checks++; if (alu_reset !== 1'b0) begin errors++; $display("FAIL post_alu_reset got=%b exp=0", alu_reset); end
    rr_ptr = 0;
  endtask

  task automatic test_directed;
    int          ids  [3] = '{1, 2, 0};
    logic        ins  [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] a   [3] = '{64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [W-1:0] b   [3] = '{64'd7, 64'd4, 64'd1};
    logic [W-1:0] er  [3] = '{64'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    logic        ec   [3] = '{1'b1, 1'b1, 1'b0};
    logic [NREQ-1:0] onehot;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      set_req(ids[n], ins[n], a[n], b[n]);
      req_valid = '0; req_valid[ids[n]] = 1'b1;
      onehot = '0; onehot[ids[n]] = 1'b1;
      #1;
      checks++; if (req_ready !== onehot) begin errors++; $display("FAIL dir%0d_grant got=%b exp=%b", n, req_ready, onehot); end
      @(posedge clk); rr_ptr = (ids[n] + 1) % NREQ;
      @(negedge clk); req_valid = '0; #1;
      checks++; if ({alu_enable, alu_instr, rsp_valid} !== {1'b1, ins[n], 1'b0}) begin errors++; $display("FAIL dir%0d_exec got=%b exp=%b", n, {alu_enable, alu_instr, rsp_valid}, {1'b1, ins[n], 1'b0}); end
      checks++; if (alu_op1 !== a[n] || alu_op2 !== b[n]) begin errors++; $display("FAIL dir%0d_ops got=%h/%h exp=%h/%h", n, alu_op1, alu_op2, a[n], b[n]); end
      @(posedge clk); @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(ids[n])) begin errors++; $display("FAIL dir%0d_rsp got=v%b id%0d exp=v1 id%0d", n, rsp_valid, rsp_id, ids[n]); end
      checks++; if (rsp_result !== er[n] || rsp_carry !== ec[n]) begin errors++; $display("FAIL dir%0d_val got=%h c%b exp=%h c%b", n, rsp_result, rsp_carry, er[n], ec[n]); end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk); rsp_ready = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_done got=%b exp=0", n, rsp_valid); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b, ea, eb;
    logic         ins, eins;
    logic [W:0]   e, e2;
    int           g;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; ins = 1'($urandom);
    e = dp(ins, a, b);
    @(negedge clk);
    set_req(3, ins, a, b); req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got=%b exp=1000", req_ready); end
    @(posedge clk); rr_ptr = 0;
    @(negedge clk);
    ea = {$urandom, $urandom}; eb = {$urandom, $urandom}; eins = 1'($urandom);
    set_req(0, eins, ea, eb); set_req(1, 1'b0, 64'd1, 64'd2);
    req_valid = 4'b0011;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || req_ready !== 4'b0) begin errors++; $display("FAIL bp_hold%0d got=v%b id%0d rdy%b exp=v1 id3 rdy0000", c, rsp_valid, rsp_id, req_ready); end
      checks++; if (rsp_result !== e[W-1:0] || rsp_carry !== e[W]) begin errors++; $display("FAIL bp_val%0d got=%h c%b exp=%h c%b", c, rsp_result, rsp_carry, e[W-1:0], e[W]); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); rsp_ready = 1'b0; #1;
    g = pick(4'b0011);
    checks++; if (req_ready !== (4'b1 << g)) begin errors++; $display("FAIL bp_next got=%b exp=%b", req_ready, 4'b1 << g); end
    e2 = (g == 0) ? dp(eins, ea, eb) : dp(1'b0, 64'd1, 64'd2);
    @(posedge clk); rr_ptr = (g + 1) % NREQ;
    @(negedge clk); req_valid = '0;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_result !== e2[W-1:0] || rsp_carry !== e2[W]) begin errors++; $display("FAIL bp_rsp2 got=v%b id%0d %h c%b exp=v1 id%0d %h c%b", rsp_valid, rsp_id, rsp_result, rsp_carry, g, e2[W-1:0], e2[W]); end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] a, b;
    logic [W:0]   e;
    @(negedge clk);
    set_req(2, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}); req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk); req_valid = 4'b0010;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    set_req(1, 1'b1, a, b); e = dp(1'b1, a, b);
    #1;
    checks++; if (alu_enable !== 1'b1) begin errors++; $display("FAIL mid_exec got=%b exp=1", alu_enable); end
    #1 reset_n = 1'b0; rr_ptr = 0; #1;
    checks++; if ({rsp_valid, alu_enable, alu_reset, req_ready} !== 7'b0010000) begin errors++; $display("FAIL mid_reset got=%b exp=0010000", {rsp_valid, alu_enable, alu_reset, req_ready}); end
    @(posedge clk); @(negedge clk); #1 reset_n = 1'b1; #1;
    checks++; if (alu_reset !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rel got=r%b v%b exp=r1 v0", alu_reset, rsp_valid); end
    @(posedge clk); #1;
    checks++; if (alu_reset !== 1'b0) begin errors++; $display("FAIL mid_alu_reset got=%b exp=0", alu_reset); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant got=%b exp=0010", req_ready); end
    @(posedge clk); rr_ptr = 2;
    @(negedge clk); req_valid = '0;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== e[W-1:0] || rsp_carry !== e[W]) begin errors++; $display("FAIL mid_rsp got=v%b id%0d %h c%b exp=v1 id1 %h c%b", rsp_valid, rsp_id, rsp_result, rsp_carry, e[W-1:0], e[W]); end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_contention;
`ifdef ALU_SCHED_RR_EN
    int order [5] = '{0, 1, 2, 3, 0};
`else
    int order [5] = '{0, 0, 0, 0, 0};
`endif
    logic [W:0] e;
    @(negedge clk); reset_n = 1'b0; #2 reset_n = 1'b1; rr_ptr = 0;
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== (4'b1 << order[n])) begin errors++; $display("FAIL cont%0d_grant got=%b exp=%b", n, req_ready, 4'b1 << order[n]); end
      e = dp(req_instr[order[n]], req_op1[order[n]*W +: W], req_op2[order[n]*W +: W]);
      @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[n]) || rsp_result !== e[W-1:0] || rsp_carry !== e[W]) begin errors++; $display("FAIL cont%0d_rsp got=v%b id%0d %h c%b exp=v1 id%0d %h c%b", n, rsp_valid, rsp_id, rsp_result, rsp_carry, order[n], e[W-1:0], e[W]); end
      @(posedge clk);
    end
    rr_ptr = (order[4] + 1) % NREQ;
    @(negedge clk); req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_random;
    bit          busy = 0;
    int          age = 0, g, exp_id = 0;
    logic [W:0]  e = '0;
    logic [NREQ-1:0] exp_rdy;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      rsp_ready = ($urandom % 3) != 0;
      #1;
      g = busy ? -1 : pick(req_valid);
      exp_rdy = (g < 0) ? '0 : (4'b1 << g);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd%0d_ready got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== (busy && age >= 2) || alu_enable !== (busy && age == 1)) begin errors++; $display("FAIL rnd%0d_ctl got=v%b en%b exp=v%b en%b", c, rsp_valid, alu_enable, busy && age >= 2, busy && age == 1); end
      if (busy && age >= 2) begin
        checks++; if (rsp_id !== 2'(exp_id) || rsp_result !== e[W-1:0] || rsp_carry !== e[W]) begin errors++; $display("FAIL rnd%0d_rsp got=id%0d %h c%b exp=id%0d %h c%b", c, rsp_id, rsp_result, rsp_carry, exp_id, e[W-1:0], e[W]); end
        if (rsp_ready) busy = 0;
      end else if (busy) begin
        age++;
      end else if (g >= 0) begin
        busy = 1; age = 1; exp_id = g;
        e = dp(req_instr[g], req_op1[g*W +: W], req_op2[g*W +: W]);
        rr_ptr = (g + 1) % NREQ;
      end
    end
    @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_contention();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
